// File: rtl/riscv_imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package riscv_imm_pkg;

   // Format code carried with every decoded entry.
   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } imm_fmt_t;

   // Major opcodes (instr[6:0]) recognised by the generator.
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;

   // Instruction bit positions of the immediate slices.
   localparam int SIGN_BIT = 31;
   localparam int I_HI     = 31;
   localparam int I_LO     = 20;
   localparam int S_HI_HI  = 31;
   localparam int S_HI_LO  = 25;
   localparam int S_LO_HI  = 11;
   localparam int S_LO_LO  = 7;
   localparam int U_HI     = 31;
   localparam int U_LO     = 12;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode front end and the immediate generator.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready/out_ready carry it; master drives inputs, slave is the generator.
// Ports: in_* request side, out_* result side, flush, illegal_cnt status.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
);
   import riscv_imm_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   imm_fmt_t         out_fmt;
   logic [XLEN-1:0]  out_target;
   logic             out_illegal;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, illegal_cnt
   );

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal, illegal_cnt
   );
endinterface

// File: rtl/fifo.sv
// Generic register FIFO with synchronous flush; head is read straight from storage.
// Latency: push in cycle N is visible at pop_dat in cycle N+1 when empty.
// Backpressure: push_rdy is low only when full (registered state, independent of pop_rdy).
// Ports: clk, rst_n, flush, push_vld/push_rdy/push_dat, pop_vld/pop_rdy/pop_dat.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   output logic         pop_vld,
   input  logic         pop_rdy,
   output logic [W-1:0] pop_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] cnt;
   logic          do_push, do_pop;

   assign push_rdy = (cnt != CW'(DEPTH));
   assign pop_vld  = (cnt != '0);
   assign pop_dat  = mem[rptr];
   assign do_push  = push_vld && push_rdy;
   assign do_pop   = pop_vld && pop_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         // Flush wins over any push/pop presented in the same cycle.
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= push_dat;
            wptr      <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/imm_extract.sv
// Combinational opcode classifier and sign-extended immediate extractor.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no state.
// Ports: instr in; imm (XLEN), fmt, illegal out.
module imm_extract
   import riscv_imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_fmt_t        fmt,
   output logic            illegal
);
   logic        sign;
   logic [31:0] raw;   // immediate already sign-extended to 32 bits

   assign sign = instr[SIGN_BIT];

   always_comb begin
      raw     = '0;
      fmt     = FMT_ILL;
      illegal = 1'b0;
      case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: begin
            // Shift funct bits in [31:25] are deliberately left in place.
            fmt = FMT_I;
            raw = {{20{sign}}, instr[I_HI:I_LO]};
         end
         OP_STORE: begin
            fmt = FMT_S;
            raw = {{20{sign}}, instr[S_HI_HI:S_HI_LO], instr[S_LO_HI:S_LO_LO]};
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            raw = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            raw = {instr[U_HI:U_LO], 12'b0};
         end
         OP_JAL: begin
            fmt = FMT_J;
            raw = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_REG, OP_REG32: begin
            fmt = FMT_R;
         end
         default: begin
            fmt     = FMT_ILL;
            illegal = 1'b1;
         end
      endcase
   end

   // raw[31] rather than instr[31] so R/ILL stay all-zero after widening.
   generate
      if (XLEN == 32) begin : g_x32
         assign imm = raw;
      end else begin : g_xwide
         assign imm = {{(XLEN-32){raw[31]}}, raw};
      end
   endgenerate
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode imm/fmt, PC-relative target, 2-entry output buffer.
// Latency: 1 cycle push-to-out_valid when empty; 1 instruction/cycle with out_ready high.
// Backpressure: in_ready low only when both buffer entries are occupied.
// Ports: clk, rst_n (async low); bus (imm_gen_pipe_if.slave) carries handshakes, flush, results, illegal_cnt.
module imm_gen_pipe
   import riscv_imm_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   imm_gen_pipe_if.slave  bus
);
   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] target;
      imm_fmt_t        fmt;
      logic            illegal;
   } entry_t;

   logic [XLEN-1:0]  ext_imm;
   imm_fmt_t         ext_fmt;
   logic             ext_ill;
   entry_t           push_dat, head;
   logic [CNT_W-1:0] cnt;
   logic             cnt_inc;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr   (bus.in_instr),
      .imm     (ext_imm),
      .fmt     (ext_fmt),
      .illegal (ext_ill)
   );

   // Everything stored is computed at push time; the head register drives the outputs.
   always_comb begin
      push_dat         = '0;
      push_dat.imm     = ext_imm;
      push_dat.target  = bus.in_pc + ext_imm;
      push_dat.fmt     = ext_fmt;
      push_dat.illegal = ext_ill;
   end

   fifo #(.W($bits(entry_t)), .DEPTH(2)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush),
      .push_vld (bus.in_valid),
      .push_rdy (bus.in_ready),
      .push_dat (push_dat),
      .pop_vld  (bus.out_valid),
      .pop_rdy  (bus.out_ready),
      .pop_dat  (head)
   );

   assign bus.out_imm     = head.imm;
   assign bus.out_target  = head.target;
   assign bus.out_fmt     = head.fmt;
   assign bus.out_illegal = head.illegal;

   // Counts only pushes that really land in the buffer; flush suppresses them.
   assign cnt_inc = bus.in_valid && bus.in_ready && !bus.flush && ext_ill && (cnt != '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign bus.illegal_cnt = cnt;
endmodule
